// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-cycle RAM port between an instruction-fetch requester and
// a load/store requester. Grants are combinational in the request cycle and
// completions appear exactly one cycle later. Load/store wins on conflict
// unless fetch has been denied STARVE_MAX cycles in a row. Stores are
// lane-positioned, loads are lane-selected and extended. Misaligned or
// illegal-size accesses complete with an error. One word address (MMIO_ADDR)
// maps to an internal output register instead of RAM.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   if_req       fetch request
//   if_addr      fetch byte address
//   if_gnt       fetch granted this cycle
//   if_rvalid    fetch data valid (cycle after grant)
//   if_rdata     fetch data (raw RAM word)
//   ls_req       load/store request
//   ls_we        1 = store, 0 = load
//   ls_size      00 byte, 01 half, 10 word, 11 illegal
//   ls_unsigned  zero-extend loads when set
//   ls_addr      load/store byte address
//   ls_wdata     store data, right-aligned
//   ls_gnt       load/store granted this cycle
//   ls_rvalid    load data valid / store or error complete
//   ls_rdata     extended load data (0 for stores and errors)
//   ls_err       misaligned or illegal-size completion
//   ram_addr     RAM address (holds last value when idle)
//   ram_we       RAM byte-lane write enables
//   ram_wdata    RAM lane-positioned write data
//   ram_rdata    RAM read data, valid one cycle after the address
//   mmio_out     MMIO output register
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int          STARVE_MAX = 4,
    parameter logic [31:0] MMIO_ADDR  = 32'h0000_0FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [31:0] mmio_out
);

    localparam int               CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    logic [CNT_W-1:0] starve_cnt;
    logic [31:0]      addr_q;

    logic             fetch_forced;
    logic             ls_misaligned;
    logic             ls_is_mmio;
    logic             ls_store_ok;
    logic             ls_ram_access;
    logic [3:0]       lane_we;
    logic [31:0]      lane_wdata;

    // Completion context captured at grant, consumed the following cycle.
    logic             rsp_if;
    logic             rsp_ls;
    logic             rsp_err;
    logic             rsp_store;
    logic             rsp_mmio;
    logic             rsp_unsigned;
    logic [1:0]       rsp_off;
    logic [1:0]       rsp_size;

    logic [31:0]      ld_src;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;

    // ------------------------------------------------------------------------
    // Arbitration. Grants are qualified by reset so every output reads 0 while
    // reset is held, even with requests pending.
    // ------------------------------------------------------------------------
    assign fetch_forced = (starve_cnt == STARVE_LIM);
    assign if_gnt       = reset & if_req & (~ls_req | fetch_forced);
    assign ls_gnt       = reset & ls_req & ~(if_req & fetch_forced);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (if_req && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Load/store decode: alignment check and store lane placement.
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, otherwise paths
    // that skip an assignment would infer a latch.
    always_comb begin
        ls_misaligned = 1'b0;
        lane_we       = 4'b0000;
        lane_wdata    = 32'h0;
        case (ls_size)
            SIZE_BYTE: begin
                lane_we    = 4'b0001 << ls_addr[1:0];
                lane_wdata = {4{ls_wdata[7:0]}};
            end
            SIZE_HALF: begin
                ls_misaligned = ls_addr[0];
                lane_we       = ls_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata    = {2{ls_wdata[15:0]}};
            end
            SIZE_WORD: begin
                ls_misaligned = |ls_addr[1:0];
                lane_we       = 4'b1111;
                lane_wdata    = ls_wdata;
            end
            default: ls_misaligned = 1'b1;
        endcase
    end

    assign ls_is_mmio    = (ls_addr[31:2] == MMIO_ADDR[31:2]);
    assign ls_store_ok   = ls_gnt & ls_we & ~ls_misaligned;
    // Flagged and MMIO accesses never touch the RAM port.
    assign ls_ram_access = ls_gnt & ~ls_misaligned & ~ls_is_mmio;

    assign ram_we    = (ls_store_ok & ~ls_is_mmio) ? lane_we : 4'b0000;
    assign ram_wdata = ls_store_ok ? lane_wdata : 32'h0;

    // RAM address holds its last driven value when no RAM access is granted.
    always_comb begin
        ram_addr = addr_q;
        if (if_gnt) begin
            ram_addr = if_addr;
        end else if (ls_ram_access) begin
            ram_addr = ls_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= ram_addr;
        end
    end

    // ------------------------------------------------------------------------
    // MMIO output register, byte-lane writable.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mmio_out <= '0;
        end else if (ls_store_ok && ls_is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we[i]) begin
                    mmio_out[8*i +: 8] <= ram_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Completion tracking. Async clear drops any in-flight completion.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_if       <= 1'b0;
            rsp_ls       <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_store    <= 1'b0;
            rsp_mmio     <= 1'b0;
            rsp_unsigned <= 1'b0;
            rsp_off      <= 2'b00;
            rsp_size     <= 2'b00;
        end else begin
            rsp_if <= if_gnt;
            rsp_ls <= ls_gnt;
            if (ls_gnt) begin
                rsp_err      <= ls_misaligned;
                rsp_store    <= ls_we;
                rsp_mmio     <= ls_is_mmio;
                rsp_unsigned <= ls_unsigned;
                rsp_off      <= ls_addr[1:0];
                rsp_size     <= ls_size;
            end
        end
    end

    assign if_rvalid = rsp_if;
    assign if_rdata  = rsp_if ? ram_rdata : 32'h0;
    assign ls_rvalid = rsp_ls;
    assign ls_err    = rsp_ls & rsp_err;

    // Load data: pick the lane from the registered offset, then extend.
    always_comb begin
        ld_src   = rsp_mmio ? mmio_out : ram_rdata;
        ld_byte  = 8'h0;
        ld_half  = 16'h0;
        ls_rdata = 32'h0;
        if (rsp_ls && !rsp_err && !rsp_store) begin
            case (rsp_size)
                SIZE_BYTE: begin
                    case (rsp_off)
                        2'd0:    ld_byte = ld_src[7:0];
                        2'd1:    ld_byte = ld_src[15:8];
                        2'd2:    ld_byte = ld_src[23:16];
                        default: ld_byte = ld_src[31:24];
                    endcase
                    ls_rdata = {{24{ld_byte[7] & ~rsp_unsigned}}, ld_byte};
                end
                SIZE_HALF: begin
                    ld_half  = rsp_off[1] ? ld_src[31:16] : ld_src[15:0];
                    ls_rdata = {{16{ld_half[15] & ~rsp_unsigned}}, ld_half};
                end
                default: ls_rdata = ld_src;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int          STARVE_MAX = 4;
    localparam logic [31:0] MMIO_ADDR  = 32'h0000_0FFC;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic        ls_unsigned;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic [31:0] ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] mmio_out;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .MMIO_ADDR  (MMIO_ADDR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .ls_req      (ls_req),
        .ls_we       (ls_we),
        .ls_size     (ls_size),
        .ls_unsigned (ls_unsigned),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_gnt      (ls_gnt),
        .ls_rvalid   (ls_rvalid),
        .ls_rdata    (ls_rdata),
        .ls_err      (ls_err),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .mmio_out    (mmio_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 2) ? 32'h0010_0093 : 32'h9E37_79B9 * 32'(i + 1);
    endfunction

    // ------------------------------------------------------------------------
    // RAM environment: 1K words, read data one cycle after the address.
    // ------------------------------------------------------------------------
    logic [31:0] ram [1024];
    bit          ram_loaded;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else begin
            ram_rdata <= ram[ram_addr[11:2]];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) ram[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Behavioural model: expected memory image, MMIO value, starvation count
    // and the completion each grant must produce next cycle.
    // ------------------------------------------------------------------------
    logic [31:0] mdl_mem [1024];
    int          m_starve, n_starve;
    logic [31:0] m_last, n_last, m_mmio, n_mmio;
    logic        p_if_v, n_if_v, p_ls_v, n_ls_v, p_ls_err, n_ls_err;
    logic [31:0] p_if_d, n_if_d, p_ls_d, n_ls_d;
    logic        n_mem_wr;
    int          n_mem_idx;
    logic [31:0] n_mem_word;

    task automatic model_step();
        logic        e_if, e_ls, bad, mm, st;
        logic [3:0]  mask, e_we;
        logic [31:0] wd, word, upd, e_addr, ld;
        int          off, idx;
        n_mem_wr = 1'b0;
        if (!reset) begin
            check("rst_if_gnt",    32'(if_gnt),    32'h0);
            check("rst_if_rvalid", 32'(if_rvalid), 32'h0);
            check("rst_if_rdata",  if_rdata,       32'h0);
            check("rst_ls_gnt",    32'(ls_gnt),    32'h0);
            check("rst_ls_rvalid", 32'(ls_rvalid), 32'h0);
            check("rst_ls_rdata",  ls_rdata,       32'h0);
            check("rst_ls_err",    32'(ls_err),    32'h0);
            check("rst_ram_addr",  ram_addr,       32'h0);
            check("rst_ram_we",    32'(ram_we),    32'h0);
            check("rst_ram_wdata", ram_wdata,      32'h0);
            check("rst_mmio_out",  mmio_out,       32'h0);
            return;
        end
        // Load/store wins unless fetch has been starved long enough.
        e_if = if_req && (!ls_req || m_starve == STARVE_MAX);
        e_ls = ls_req && !e_if;
        off  = int'(ls_addr[1:0]);
        idx  = int'(ls_addr[11:2]);
        bad  = (ls_size == SZ_X) || (ls_size == SZ_H && off % 2 != 0) ||
               (ls_size == SZ_W && off != 0);
        mm   = ((ls_addr >> 2) == (MMIO_ADDR >> 2));
        st   = e_ls && ls_we && !bad;
        mask = 4'h0;
        wd   = 32'h0;
        case (ls_size)
            SZ_B: begin mask = 4'(1 << off); wd = {24'h0, ls_wdata[7:0]} * 32'h0101_0101; end
            SZ_H: begin mask = (off >= 2) ? 4'hC : 4'h3; wd = {16'h0, ls_wdata[15:0]} * 32'h0001_0001; end
            SZ_W: begin mask = 4'hF; wd = ls_wdata; end
            default: ;
        endcase
        word = mm ? m_mmio : mdl_mem[idx];
        upd  = word;
        for (int b = 0; b < 4; b++) if (mask[b]) upd[8*b +: 8] = wd[8*b +: 8];
        n_mmio = m_mmio;
        if (st && mm) n_mmio = upd;
        if (st && !mm) begin
            n_mem_wr   = 1'b1;
            n_mem_idx  = idx;
            n_mem_word = upd;
        end
        e_we   = (st && !mm) ? mask : 4'h0;
        e_addr = e_if ? if_addr : (e_ls && !bad && !mm) ? ls_addr : m_last;
        ld = word >> (8 * off);
        case (ls_size)
            SZ_B: begin ld = ld & 32'hFF;   if (!ls_unsigned && ld[7])  ld = ld | 32'hFFFF_FF00; end
            SZ_H: begin ld = ld & 32'hFFFF; if (!ls_unsigned && ld[15]) ld = ld | 32'hFFFF_0000; end
            default: ;
        endcase
        if (bad || ls_we) ld = 32'h0;

        check("if_gnt",    32'(if_gnt),    32'(e_if));
        check("ls_gnt",    32'(ls_gnt),    32'(e_ls));
        check("ram_we",    32'(ram_we),    32'(e_we));
        check("ram_addr",  ram_addr,       e_addr);
        if (st) check("ram_wdata", ram_wdata, wd);
        check("mmio_out",  mmio_out,       m_mmio);
        check("if_rvalid", 32'(if_rvalid), 32'(p_if_v));
        if (p_if_v) check("if_rdata", if_rdata, p_if_d);
        check("ls_rvalid", 32'(ls_rvalid), 32'(p_ls_v));
        check("ls_err",    32'(ls_err),    32'(p_ls_v && p_ls_err));
        if (p_ls_v) check("ls_rdata", ls_rdata, p_ls_d);

        n_starve = e_if ? 0 : (if_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : m_starve) : m_starve);
        n_last   = e_addr;
        n_if_v   = e_if;
        n_if_d   = mdl_mem[if_addr[11:2]];
        n_ls_v   = e_ls;
        n_ls_err = bad;
        n_ls_d   = ld;
    endtask

    initial begin : compare
        for (int i = 0; i < 1024; i++) mdl_mem[i] = init_word(i);
        m_starve = 0; m_last = '0; m_mmio = '0;
        p_if_v = 1'b0; p_ls_v = 1'b0; p_ls_err = 1'b0;
        p_if_d = '0; p_ls_d = '0;
        forever begin
            @(negedge clk);
            model_step();
            @(posedge clk);
            if (!reset) begin
                m_starve = 0; m_last = '0; m_mmio = '0;
                p_if_v = 1'b0; p_ls_v = 1'b0;
            end else begin
                m_starve = n_starve; m_last = n_last; m_mmio = n_mmio;
                p_if_v = n_if_v; p_if_d = n_if_d;
                p_ls_v = n_ls_v; p_ls_err = n_ls_err; p_ls_d = n_ls_d;
                if (n_mem_wr) mdl_mem[n_mem_idx] = n_mem_word;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus with literal expectations.
    // ------------------------------------------------------------------------
    task automatic drive(input logic fi, input logic [31:0] fa, input logic li, input logic we,
                         input logic [1:0] sz, input logic uns, input logic [31:0] la,
                         input logic [31:0] wd);
        @(posedge clk);
        #1;
        if_req = fi; if_addr = fa;
        ls_req = li; ls_we = we; ls_size = sz; ls_unsigned = uns; ls_addr = la; ls_wdata = wd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = SZ_W; ls_unsigned = 1'b0; ls_addr = '0; ls_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Single fetch.
        drive(1'b1, 32'h8, 1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("fetch_gnt",  32'(if_gnt), 32'h1);
        check("fetch_addr", ram_addr,    32'h8);
        idle();
        @(negedge clk);
        check("fetch_rvalid", 32'(if_rvalid), 32'h1);
        check("fetch_rdata",  if_rdata,       32'h0010_0093);
        check("idle_addr_hold", ram_addr,     32'h8);

        // Both requesters held: LS,LS,LS,LS,IF repeating.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h8, 1'b1, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            check($sformatf("starve_pattern_%0d", i), 32'({if_gnt, ls_gnt}),
                  (i % 5 == 4) ? 32'h2 : 32'h1);
        end
        idle();

        // Byte store, then signed and unsigned byte loads.
        drive(1'b0, 32'h0, 1'b1, 1'b1, SZ_B, 1'b0, 32'h102, 32'h0000_00AB);
        @(negedge clk);
        check("sb_we",    32'(ram_we), 32'h4);
        check("sb_wdata", ram_wdata,   32'hABAB_ABAB);
        drive(1'b0, 32'h0, 1'b1, 1'b0, SZ_B, 1'b0, 32'h102, 32'h0);
        @(negedge clk);
        check("sb_done_rvalid", 32'(ls_rvalid), 32'h1);
        check("sb_done_rdata",  ls_rdata,       32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, SZ_B, 1'b1, 32'h102, 32'h0);
        @(negedge clk);
        check("lb_signed", ls_rdata, 32'hFFFF_FFAB);
        idle();
        @(negedge clk);
        check("lbu", ls_rdata, 32'h0000_00AB);

        // Half store to upper half, half and byte loads.
        drive(1'b0, 32'h0, 1'b1, 1'b1, SZ_H, 1'b0, 32'h102, 32'h0000_BEEF);
        @(negedge clk);
        check("sh_we",    32'(ram_we), 32'hC);
        check("sh_wdata", ram_wdata,   32'hBEEF_BEEF);
        drive(1'b0, 32'h0, 1'b1, 1'b0, SZ_H, 1'b0, 32'h102, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, SZ_B, 1'b0, 32'h103, 32'h0);
        @(negedge clk);
        check("lh_signed", ls_rdata, 32'hFFFF_BEEF);
        drive(1'b0, 32'h0, 1'b1, 1'b0, SZ_H, 1'b1, 32'h100, 32'h0);
        @(negedge clk);
        check("lb_upper", ls_rdata, 32'hFFFF_FFBE);
        idle();

        // MMIO word store, byte store into lane 1, load back.
        drive(1'b0, 32'h0, 1'b1, 1'b1, SZ_W, 1'b0, 32'hFFC, 32'h0000_0004);
        @(negedge clk);
        check("mmio_st_we", 32'(ram_we), 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0, 32'hFFC, 32'h0);
        @(negedge clk);
        check("mmio_after_edge", mmio_out, 32'h0000_0004);
        drive(1'b0, 32'h0, 1'b1, 1'b1, SZ_B, 1'b0, 32'hFFD, 32'h0000_005A);
        @(negedge clk);
        check("mmio_ld", ls_rdata, 32'h0000_0004);
        idle();
        @(negedge clk);
        check("mmio_byte", mmio_out, 32'h0000_5A04);

        // Misaligned and illegal-size accesses.
        drive(1'b0, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0, 32'h102, 32'h0);
        @(negedge clk);
        check("mis_gnt", 32'(ls_gnt), 32'h1);
        check("mis_we",  32'(ram_we), 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, SZ_H, 1'b0, 32'h101, 32'h0000_1234);
        @(negedge clk);
        check("mis_err",    32'(ls_err),    32'h1);
        check("mis_rvalid", 32'(ls_rvalid), 32'h1);
        check("mis_rdata",  ls_rdata,       32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, SZ_X, 1'b0, 32'hFFC, 32'hFFFF_FFFF);
        @(negedge clk);
        check("sh_mis_we", 32'(ram_we), 32'h0);
        idle();
        @(negedge clk);
        check("illegal_err",      32'(ls_err), 32'h1);
        check("illegal_no_mmio",  mmio_out,    32'h0000_5A04);

        // Load granted, then reset before its completion edge.
        drive(1'b0, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("rst_pre_gnt", 32'(ls_gnt), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("rst_gnt_gated", 32'(ls_gnt), 32'h0);
        check("rst_mmio_clr",  mmio_out,    32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("rst_no_rvalid_%0d", i), 32'(ls_rvalid), 32'h0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h8; ls_req = 1'b0;
        @(negedge clk);
        check("post_rst_gnt", 32'(if_gnt), 32'h1);
        idle();
        @(negedge clk);
        check("post_rst_fetch", if_rdata, 32'h0010_0093);
        idle();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, meaning consecutive fetch-denied cycles before fetch is forced to win.
REQ-002 Parameter MMIO_ADDR, default 32'h0000_0FFC, meaning word address of the output MMIO register.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  fetch request.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_gnt  out  1  fetch granted this cycle.
REQ-008 if_rvalid  out  1  fetch data valid.
REQ-009 if_rdata  out  32  fetch data.
REQ-010 ls_req  in  1  load/store request.
REQ-011 ls_we  in  1  1 = store, 0 = load.
REQ-012 ls_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-013 ls_unsigned  in  1  zero-extend the load when set.
REQ-014 ls_addr  in  32  load/store byte address.
REQ-015 ls_wdata  in  32  store data, right-aligned.
REQ-016 ls_gnt  out  1  load/store granted this cycle.
REQ-017 ls_rvalid  out  1  load data valid or store/error complete.
REQ-018 ls_rdata  out  32  extended load data.
REQ-019 ls_err  out  1  misaligned or illegal-size completion.
REQ-020 ram_addr  out  32  shared single RAM port address.
REQ-021 ram_we  out  4  byte-lane write enables.
REQ-022 ram_wdata  out  32  lane-positioned write data.
REQ-023 ram_rdata  in  32  RAM read data, valid one cycle after the address.
REQ-024 mmio_out  out  32  MMIO register contents.

Function
REQ-025 The block SHALL drive one RAM port, one transaction per cycle; grant is combinational in the request cycle, and completion (rvalid) SHALL be asserted exactly one cycle later.
REQ-026 Arbitration: the load/store path SHALL win on conflict, except when starve_cnt == STARVE_MAX, in which case fetch SHALL win and starve_cnt SHALL clear.
REQ-027 starve_cnt SHALL increment when if_req=1 and if_gnt=0, SHALL clear when if_gnt=1, and SHALL saturate at STARVE_MAX.
REQ-028 A requester SHALL be granted only while its req=1; with no request, ram_we=0 and ram_addr holds its last value.
REQ-029 Misaligned accesses SHALL be flagged: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
REQ-030 A flagged access SHALL be granted but SHALL produce no RAM write and no MMIO write; the next cycle SHALL give ls_rvalid=1, ls_err=1, ls_rdata=0.
REQ-031 Store lanes:
  - byte: wdata={4{b}}, we=1<<addr[1:0];
  - half: wdata={2{h}}, we=addr[1]?1100:0011;
  - word: we=1111.
REQ-032 A store or load to word address MMIO_ADDR SHALL NOT reach RAM (ram_we=0).
  - Store: mmio_out SHALL be updated per lane from ram_wdata at the clock edge.
  - Load: SHALL return mmio_out, extended as in REQ-033.
REQ-033 Loads SHALL use registered addr[1:0], size and unsigned flags: select the lane, then sign- or zero-extend to 32 bits.
REQ-034 Store completion SHALL assert ls_rvalid=1 with ls_rdata=0.
REQ-035 Fetch data SHALL be raw ram_rdata with if_rvalid=1.
REQ-036 Simultaneous requests SHALL produce exactly one gnt per cycle; the denied requester SHALL hold its request.

Reset
REQ-037 While reset=0, all outputs SHALL be 0, mmio_out=0, starve_cnt=0, and in-flight completions SHALL be discarded.
REQ-038 Reset assertion mid-transaction SHALL suppress the pending rvalid; the first grant SHALL be possible on the first clk edge after release.

Verification
REQ-039 Fetch only, if_addr=0x8, RAM word=0x00100093 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0x00100093.
REQ-040 ls_req and if_req held high for 10 cycles, STARVE_MAX=4 -> grant pattern LS,LS,LS,LS,IF repeating.
REQ-041 Byte store 0xAB to 0x102 -> ram_we=0100, ram_wdata=0xABABABAB; signed byte load from 0x102 -> ls_rdata=0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-042 Word store 0x4 to 0xFFC -> ram_we=0000, mmio_out=0x00000004 after the edge; word load from 0xFFC -> ls_rdata=0x00000004.
REQ-043 Word load from 0x102 -> next cycle ls_err=1, ls_rvalid=1, no RAM access.
REQ-044 reset pulled low one cycle after a load grant -> ls_rvalid never asserts; all outputs 0.
